// File: rtl/sqrt_pkg.sv
// Shared elaboration-time helpers for the pipelined square-root block.
// No ports: this package only provides width and stage-count functions
// used by the interface and the pipeline top.
package sqrt_pkg;

   // Root width for a given radicand width: ceil(width_in / 2).
   function automatic int unsigned root_width(input int unsigned width_in);
      return (width_in / 32'd2) + (width_in % 32'd2);
   endfunction

   // Number of register stages when each stage resolves iters root bits.
   function automatic int unsigned stage_count(input int unsigned width_out,
                                               input int unsigned iters);
      return width_out / iters;
   endfunction

   // The remainder is bounded by 2*root, so it needs one bit more than the root.
   function automatic int unsigned rem_width(input int unsigned width_out);
      return width_out + 32'd1;
   endfunction

endpackage

// File: rtl/sqrt_remainder_pipe_if.sv
// Operand/result handshake bundle for sqrt_remainder_pipe.
// Operand side : valid_in, ready_in, radicand, tag_in
// Result side  : valid_out, ready_out, root, remainder, tag_out
// slave modport is the pipeline's view; master is the producer/consumer view.
interface sqrt_remainder_pipe_if #(
   parameter int WIDTH_INPUT = 16,
   parameter int TAG_WIDTH   = 4
);
   import sqrt_pkg::*;

   localparam int WIDTH_OUTPUT = int'(root_width(WIDTH_INPUT));

   logic                    valid_in;
   logic                    ready_in;
   logic [WIDTH_INPUT-1:0]  radicand;
   logic [TAG_WIDTH-1:0]    tag_in;
   logic                    valid_out;
   logic                    ready_out;
   logic [WIDTH_OUTPUT-1:0] root;
   logic [WIDTH_OUTPUT:0]   remainder;
   logic [TAG_WIDTH-1:0]    tag_out;

   modport slave (
      input  valid_in, radicand, tag_in, ready_out,
      output ready_in, valid_out, root, remainder, tag_out
   );

   modport master (
      output valid_in, radicand, tag_in, ready_out,
      input  ready_in, valid_out, root, remainder, tag_out
   );

endinterface

// File: rtl/sqrt_stage.sv
// Combinational slice of the restoring square-root recurrence.
// Resolves ITERS root bits, MSB first, consuming two radicand bits per bit.
// Ports: root_i/rem_i  partial root and remainder entering the slice
//        rad_i         the 2*ITERS radicand bits consumed here (MSB first)
//        root_o/rem_o  updated partial root and remainder
module sqrt_stage #(
   parameter int WIDTH_ROOT = 8,
   parameter int ITERS      = 1
) (
   input  logic [WIDTH_ROOT-1:0] root_i,
   input  logic [WIDTH_ROOT:0]   rem_i,
   input  logic [2*ITERS-1:0]    rad_i,
   output logic [WIDTH_ROOT-1:0] root_o,
   output logic [WIDTH_ROOT:0]   rem_o
);
   // Two guard bits above the remainder hold 4*rem + 3 before the trial subtract.
   localparam int WORK_W = WIDTH_ROOT + 3;

   logic [WORK_W-1:0]     rem_s;
   logic [WORK_W-1:0]     trial_s;
   logic [WIDTH_ROOT-1:0] root_s;

   // Unrolled restoring iterations: subtract 4*root+1 when it fits.
   always_comb begin
      root_s  = root_i;
      rem_s   = {2'b00, rem_i};
      trial_s = '0;
      for (int i = 0; i < ITERS; i++) begin
         // rem <= 2*root keeps the upper guard bits zero here, so nothing is lost
         rem_s   = {rem_s[WIDTH_ROOT:0], rad_i[2*(ITERS-1-i) +: 2]};
         trial_s = {1'b0, root_s, 2'b01};
         root_s  = root_s << 1;
         if (rem_s >= trial_s) begin
            rem_s     = rem_s - trial_s;
            root_s[0] = 1'b1;
         end else begin
            root_s[0] = 1'b0;
         end
      end
      root_o = root_s;
      rem_o  = rem_s[WIDTH_ROOT:0];
   end

endmodule

// File: rtl/sqrt_remainder_pipe.sv
// Pipelined integer square root with remainder and a sideband tag.
// Ports: clk    rising-edge clock
//        rst_n  asynchronous active-low reset; empties the pipe
//        bus    slave side of sqrt_remainder_pipe_if (operand in, result out)
// root = floor(sqrt(radicand)), remainder = radicand - root*root.
// Each stage register holds valid, partial root, partial remainder, tag and
// the radicand bits not yet consumed; the whole pipe shifts on advance.
module sqrt_remainder_pipe #(
   parameter int WIDTH_INPUT     = 16,
   parameter int WIDTH_OUTPUT    = int'(sqrt_pkg::root_width(WIDTH_INPUT)),
   parameter int ITERS_PER_STAGE = 1,
   parameter int TAG_WIDTH       = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   sqrt_remainder_pipe_if.slave bus
);
   import sqrt_pkg::*;

   localparam int NSTAGES = int'(stage_count(WIDTH_OUTPUT, ITERS_PER_STAGE));
   localparam int REM_W   = int'(rem_width(WIDTH_OUTPUT));
   localparam int RAD_W   = 2 * WIDTH_OUTPUT;
   localparam int TAKE_W  = 2 * ITERS_PER_STAGE;

   logic             advance_s;
   logic [RAD_W-1:0] rad_pad_s;

   // Zero-extend an odd-width radicand to an even number of bits.
   always_comb begin
      rad_pad_s                  = '0;
      rad_pad_s[WIDTH_INPUT-1:0] = bus.radicand;
   end

   for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
      // radicand bits still unconsumed on entry to this stage
      localparam int REST_W = RAD_W - TAKE_W * s;

      logic                    valid_src_s;
      logic [WIDTH_OUTPUT-1:0] root_src_s;
      logic [REM_W-1:0]        rem_src_s;
      logic [REST_W-1:0]       rest_src_s;
      logic [TAG_WIDTH-1:0]    tag_src_s;
      logic [WIDTH_OUTPUT-1:0] root_s;
      logic [REM_W-1:0]        rem_s;
      logic                    valid_d, valid_q;
      logic [WIDTH_OUTPUT-1:0] root_d, root_q;
      logic [REM_W-1:0]        rem_d, rem_q;
      logic [TAG_WIDTH-1:0]    tag_d, tag_q;

      if (s == 0) begin : g_src
         assign valid_src_s = bus.valid_in;
         assign root_src_s  = '0;
         assign rem_src_s   = '0;
         assign rest_src_s  = rad_pad_s;
         assign tag_src_s   = bus.tag_in;
      end else begin : g_src
         assign valid_src_s = g_stage[s-1].valid_q;
         assign root_src_s  = g_stage[s-1].root_q;
         assign rem_src_s   = g_stage[s-1].rem_q;
         assign rest_src_s  = g_stage[s-1].g_rest.rest_q;
         assign tag_src_s   = g_stage[s-1].tag_q;
      end

      sqrt_stage #(
         .WIDTH_ROOT (WIDTH_OUTPUT),
         .ITERS      (ITERS_PER_STAGE)
      ) u_stage (
         .root_i (root_src_s),
         .rem_i  (rem_src_s),
         .rad_i  (rest_src_s[REST_W-1 -: TAKE_W]),
         .root_o (root_s),
         .rem_o  (rem_s)
      );

      // Shift on advance; bubbles load zero data so an empty output reads zero.
      always_comb begin
         valid_d = valid_q;
         root_d  = root_q;
         rem_d   = rem_q;
         tag_d   = tag_q;
         if (advance_s) begin
            valid_d = valid_src_s;
            if (valid_src_s) begin
               root_d = root_s;
               rem_d  = rem_s;
               tag_d  = tag_src_s;
            end else begin
               root_d = '0;
               rem_d  = '0;
               tag_d  = '0;
            end
         end else begin
            valid_d = valid_q;
         end
      end

      // Stage register; reset empties the stage.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            root_q  <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
         end else begin
            valid_q <= valid_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
         end
      end

      // The last stage has no radicand bits left to carry.
      if (s < NSTAGES - 1) begin : g_rest
         logic [REST_W-TAKE_W-1:0] rest_d, rest_q;

         // Carry the unconsumed radicand bits alongside their operand.
         always_comb begin
            rest_d = rest_q;
            if (advance_s) begin
               rest_d = valid_src_s ? rest_src_s[REST_W-TAKE_W-1:0] : '0;
            end else begin
               rest_d = rest_q;
            end
         end

         // Radicand-bits register; cleared with the rest of the stage.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rest_q <= '0;
            end else begin
               rest_q <= rest_d;
            end
         end
      end
   end

   // The pipe moves whenever the final slot is empty or being drained.
   assign advance_s     = bus.ready_out || !g_stage[NSTAGES-1].valid_q;
   assign bus.ready_in  = advance_s;
   assign bus.valid_out = g_stage[NSTAGES-1].valid_q;
   assign bus.root      = g_stage[NSTAGES-1].root_q;
   assign bus.remainder = g_stage[NSTAGES-1].rem_q;
   assign bus.tag_out   = g_stage[NSTAGES-1].tag_q;

endmodule
